matmul_seq: RTL and testbench
=============================

# matmul_seq

Operand sequencer for the 10x10 signed 8-bit matrix multiplier; sits directly upstream of the 10-lane dot-product MAC. Holds matrices A and B in internal registers loaded through a byte-wide write port. On `start`, it presents row i of A and column j of B to the MAC for all 100 (i,j) pairs in row-major order. It captures each 16-bit sum of products and streams it out as element C[i][j].

## Interface
Parameters:
- `N`, 10, matrix dimension (rows = columns = dot-product length)
- `DW`, 8, operand width (signed)
- `SW`, 16, result width (signed, matches MAC `SOP`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ld_en`  in  1  operand write strobe
- `ld_sel`  in  1  0 = write A, 1 = write B
- `ld_addr`  in  7  element index, row*N+col, valid 0..99
- `ld_data`  in  DW  signed operand value
- `start`  in  1  begin multiplication (sampled in IDLE only)
- `busy`  out  1  high while the sequence is running
- `done`  out  1  one-cycle pulse after the last result
- `a_row`  out  N*DW  `a_row[8k+7:8k]` = A[i][k], k = 0..9, to MAC `a_i_k`
- `b_col`  out  N*DW  `b_col[8k+7:8k]` = B[k][j], to MAC `b_j_k`
- `W_en`  out  1  MAC write enable
- `SOP`  in  SW  signed dot product returned from the MAC
- `c_wr`  out  1  result valid strobe
- `c_addr`  out  7  result index i*N+j
- `c_data`  out  SW  result C[i][j]

## Operation
- Storage: A and B are each 100 x 8-bit registers, cleared to 0 on reset.
- Loading: on a clock edge with `ld_en`=1, `busy`=0 and `ld_addr`<100, the selected matrix element is written.
  - `ld_en` is ignored while `busy`=1 or when `ld_addr`>=100.
- Counters: i (row) and j (col), 0..9 each. j increments fastest; j wraps 9->0 and increments i. The pair i=9, j=9 is the last.
- FSM states: IDLE, ISSUE, CAPT, FIN.
  - IDLE: `busy`=0. On `start`=1 go to ISSUE with i=j=0.
  - ISSUE: drive `a_row`/`b_col` for (i,j) and `W_en`=1. Always go to CAPT. On this edge, register `c_data`<=`SOP`, `c_addr`<=i*10+j, `c_wr`<=1.
  - CAPT: `W_en`=0, `c_wr`=1, and `a_row`/`b_col` held unchanged.
    - Last pair: go to FIN.
    - Otherwise: advance (i,j) and go to ISSUE.
  - FIN: `done`=1, `busy`=0. Go to IDLE.
- `start` is ignored in every state other than IDLE; no queuing.
- Arithmetic: no arithmetic is performed on `SOP`. It is passed through unchanged; the MAC's 16-bit wrap applies.
- `a_row` and `b_col` are registered and change only on ISSUE entry. They hold their last value in IDLE and FIN.
- Reset values: `busy`=0, `done`=0, `W_en`=0, `c_wr`=0, `c_addr`=0, `c_data`=0, `a_row`=0, `b_col`=0. State is IDLE, i=j=0.
- Reset mid-run: the run aborts immediately (asynchronously), all outputs take their reset values, and A and B are cleared. No `done` is produced.

## Timing
- Let cycle 0 be the edge that samples `start`=1 in IDLE.
- Cycle 1: ISSUE (0,0), `busy`=1, `W_en`=1.
- Cycle 2: CAPT, `c_wr`=1, `c_addr`=0.
- Element n (0..99): ISSUE at cycle 2n+1, CAPT at cycle 2n+2.
- `busy` is high for cycles 1..200. `done`=1 in cycle 201. IDLE resumes at cycle 202.
- A new `start` is accepted from cycle 202.
- The MAC path is combinational: `SOP` must be valid within the ISSUE cycle.
- `c_wr` never fires on two consecutive cycles. Exactly 100 `c_wr` pulses occur per run.
- A load issued in the same cycle as `start` (in IDLE) is written; the run uses the updated value.

## Test plan
- Reset check: assert `rst`=0 asynchronously mid-cycle. All outputs read 0 and `busy`=0 without a clock edge.
- Identity times B:
  - Stimulus: load A=I and B[r][c]=r*10+c-50, then `start`.
  - Required response: 100 `c_wr` pulses with `c_addr` 0..99 in order and `c_data`=B[i][j]. `done` at cycle 201.
- Saturating operands:
  - Stimulus: A=B=all -128, with the MAC connected.
  - Required response: every `c_data` equals the MAC's 16-bit wrapped value of 10*16384 = 163840 mod 65536 = 32768, i.e. -32768 signed.
- Ignored inputs:
  - Stimulus: pulse `start` and `ld_en` (A[0], value 5) at cycle 50 of a run, and `ld_addr`=120 while in IDLE.
  - Required response: no restart, A[0] unchanged, and the next run's results are unaffected.
- Reset mid-run: drop `rst` at cycle 100.
  - Required response: `busy`/`c_wr`/`W_en` go to 0 immediately and there is no `done`.
  - After reload, a fresh `start` produces the full 100-result sequence.
- Back-to-back runs: a `start` at cycle 202 after the previous `start` is accepted. Cycle 203 shows ISSUE (0,0) with `W_en`=1.

Source files
------------

// File: rtl/matmul_seq.sv
// matmul_seq: operand sequencer for a 10x10 signed matrix multiply.
// Holds A and B, feeds a_row/b_col to the dot-product MAC, streams C.
// Ports:
//   clk, rst (async, active-low)
//   ld_en/ld_sel/ld_addr/ld_data : byte-wide write of A (sel=0) or B (sel=1)
//   start, busy, done            : run control and status
//   a_row, b_col, W_en, SOP      : MAC operand lanes, enable, returned sum
//   c_wr, c_addr, c_data         : result stream C[i][j] at index i*N+j
`timescale 1ns/1ps
module matmul_seq #(
  parameter int N  = 10,
  parameter int DW = 8,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [6:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [N*DW-1:0] a_row,
  output logic [N*DW-1:0] b_col,
  output logic          W_en,
  input  logic [SW-1:0] SOP,
  output logic          c_wr,
  output logic [6:0]    c_addr,
  output logic [SW-1:0] c_data
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    FIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] i, j, i_n, j_n;
  logic [DW-1:0] a_mem [N*N];
  logic [DW-1:0] b_mem [N*N];

  logic wr_ok, wr_a, wr_b;
  logic issue_go, last;
  logic [6:0] ai, bi, cur_addr;
  logic [N*DW-1:0] a_nxt, b_nxt;

  assign busy  = (state == ISSUE) || (state == CAPT);
  assign W_en  = (state == ISSUE);
  assign done  = (state == FIN);
  assign wr_ok = ld_en && !busy && (ld_addr < 7'(N*N));
  assign wr_a  = wr_ok && !ld_sel;
  assign wr_b  = wr_ok && ld_sel;
  assign last  = (i == CW'(N-1)) && (j == CW'(N-1));
  assign cur_addr = 7'(i) * 7'(N) + 7'(j);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    issue_go = 1'b0;
    i_n      = i;
    j_n      = j;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = ISSUE;
          issue_go = 1'b1;
          i_n      = '0;
          j_n      = '0;
        end
      end
      ISSUE: state_n = CAPT;
      CAPT: begin
        if (last) begin
          state_n = FIN;
        end else begin
          state_n  = ISSUE;
          issue_go = 1'b1;
          if (j == CW'(N-1)) begin
            j_n = '0;
            i_n = i + 1'b1;
          end else begin
            j_n = j + 1'b1;
          end
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand lanes for the next pair. A write landing on the same edge
  // as start is forwarded so the first issue sees the new value.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    ai    = '0;
    bi    = '0;
    for (int k = 0; k < N; k++) begin
      ai = 7'(i_n) * 7'(N) + 7'(k);
      bi = 7'(k) * 7'(N) + 7'(j_n);
      a_nxt[k*DW +: DW] = (wr_a && ld_addr == ai) ? ld_data : a_mem[ai];
      b_nxt[k*DW +: DW] = (wr_b && ld_addr == bi) ? ld_data : b_mem[bi];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < N*N; m++) begin
        a_mem[m] <= '0;
        b_mem[m] <= '0;
      end
    end else begin
      if (wr_a) a_mem[ld_addr] <= ld_data;
      if (wr_b) b_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i      <= '0;
      j      <= '0;
      a_row  <= '0;
      b_col  <= '0;
      c_wr   <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
    end else begin
      i    <= i_n;
      j    <= j_n;
      c_wr <= (state == ISSUE);
      if (issue_go) begin
        a_row <= a_nxt;
        b_col <= b_nxt;
      end
      if (state == ISSUE) begin
        c_data <= SOP;
        c_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed bench for matmul_seq with a behavioural MAC.
// Drives loads and runs, records each cycle, checks the result stream.
`timescale 1ns/1ps
module tb_matmul_seq;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  logic ld_sel = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic start = 1'b0;
  logic busy, done, W_en, c_wr;
  logic [N*DW-1:0] a_row, b_col;
  logic [SW-1:0] SOP, c_data;
  logic [6:0] c_addr;

  int total = 0;
  int bad = 0;

  bit ob_busy [203];
  bit ob_wen  [203];
  bit ob_cwr  [203];
  bit ob_done [203];
  logic [6:0]    ob_addr [203];
  logic [SW-1:0] ob_data [203];
  logic [SW-1:0] exp_c [100];

  always #5 clk = ~clk;

  matmul_seq #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk(clk),
    .rst(rst),
    .ld_en(ld_en),
    .ld_sel(ld_sel),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .start(start),
    .busy(busy),
    .done(done),
    .a_row(a_row),
    .b_col(b_col),
    .W_en(W_en),
    .SOP(SOP),
    .c_wr(c_wr),
    .c_addr(c_addr),
    .c_data(c_data)
  );

  function automatic logic [SW-1:0] mac(input logic [N*DW-1:0] a,
                                        input logic [N*DW-1:0] b);
    logic signed [31:0] s;
    logic signed [7:0] x, y;
    s = 0;
    for (int k = 0; k < N; k++) begin
      x = a[k*8 +: 8];
      y = b[k*8 +: 8];
      s = s + x * y;
    end
    return s[15:0];
  endfunction

  assign SOP = mac(a_row, b_col);

  // All tasks start and end at posedge+1.
  task automatic load(input bit sel, input int addr, input int val);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 7'(addr);
    ld_data = 8'(val);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_a_ident();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        load(1'b0, r*N + c, (r == c) ? 1 : 0);
  endtask

  task automatic load_b_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        load(1'b1, r*N + c, r*10 + c - 50);
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records cycles 1..202 of a run; kind 1 pulses start and a load at inj.
  task automatic collect(input int kind, input int inj);
    for (int c = 1; c <= 202; c++) begin
      ob_busy[c] = busy;
      ob_wen[c]  = W_en;
      ob_cwr[c]  = c_wr;
      ob_done[c] = done;
      ob_addr[c] = c_addr;
      ob_data[c] = c_data;
      if (kind == 1 && c == inj) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = 7'd0;
        ld_data = 8'd5;
      end
      if (c < 202) begin
        @(posedge clk); #1;
        start = 1'b0;
        ld_en = 1'b0;
      end
    end
  endtask

  function automatic int seq_errs();
    int e;
    bit xb, xw, xc, xd;
    int n;
    e = 0;
    for (int c = 1; c <= 202; c++) begin
      xb = (c <= 200);
      xw = (c <= 199) && (c % 2 == 1);
      xc = (c >= 2) && (c <= 200) && (c % 2 == 0);
      xd = (c == 201);
      if (ob_busy[c] !== xb) e++;
      if (ob_wen[c] !== xw) e++;
      if (ob_cwr[c] !== xc) e++;
      if (ob_done[c] !== xd) e++;
      if (xc) begin
        n = (c - 2) / 2;
        if (ob_addr[c] !== 7'(n)) e++;
        if (ob_data[c] !== exp_c[n]) e++;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    total++;
    if ({busy, done, W_en, c_wr} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000", {busy, done, W_en, c_wr});
    end
    total++;
    if (c_addr !== 7'd0) begin
      bad++;
      $display("FAIL reset_addr got=%0d want=0", c_addr);
    end
    total++;
    if (c_data !== 16'd0) begin
      bad++;
      $display("FAIL reset_data got=%0h want=0", c_data);
    end
    total++;
    if (a_row !== '0 || b_col !== '0) begin
      bad++;
      $display("FAIL reset_lanes got=%0h/%0h want=0", a_row, b_col);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_identity();
    int cnt, e;
    load_a_ident();
    load_b_ramp();
    for (int n = 0; n < 100; n++) exp_c[n] = 16'(n - 50);
    launch();
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL ident_seq errors got=%0d want=0", e);
    end
    total++;
    if (ob_data[2] !== 16'hFFCE) begin
      bad++;
      $display("FAIL ident_first got=%0h want=ffce", ob_data[2]);
    end
    cnt = 0;
    for (int c = 1; c <= 202; c++) if (ob_cwr[c]) cnt++;
    total++;
    if (cnt !== 100) begin
      bad++;
      $display("FAIL ident_cwr_count got=%0d want=100", cnt);
    end
    total++;
    if (a_row !== {8'd1, 72'd0}) begin
      bad++;
      $display("FAIL ident_hold got=%0h want=%0h", a_row, {8'd1, 72'd0});
    end
  endtask

  task automatic test_saturate();
    int e;
    for (int m = 0; m < 100; m++) begin
      load(1'b0, m, -128);
      load(1'b1, m, -128);
    end
    for (int n = 0; n < 100; n++) exp_c[n] = 16'h8000;
    launch();
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL sat_seq errors got=%0d want=0", e);
    end
    total++;
    if (ob_data[200] !== 16'h8000) begin
      bad++;
      $display("FAIL sat_last got=%0h want=8000", ob_data[200]);
    end
  endtask

  task automatic test_ignored();
    int e;
    load_a_ident();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        load(1'b1, r*N + c, r - c);
    for (int n = 0; n < 100; n++) exp_c[n] = 16'((n / 10) - (n % 10));
    launch();
    collect(1, 50);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL ign_no_restart errors got=%0d want=0", e);
    end
    load(1'b0, 120, 77);
    launch();
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL ign_next_run errors got=%0d want=0", e);
    end
    total++;
    if (ob_data[4] !== 16'hFFFF) begin
      bad++;
      $display("FAIL ign_a0 got=%0h want=ffff", ob_data[4]);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    launch();
    for (int c = 1; c < 100; c++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({busy, c_wr, W_en, done} !== 4'b0) begin
      bad++;
      $display("FAIL mid_async got=%b want=0000", {busy, c_wr, W_en, done});
    end
    total++;
    if (a_row !== '0 || c_data !== '0 || c_addr !== '0) begin
      bad++;
      $display("FAIL mid_outs got=%0h/%0h/%0d want=0", a_row, c_data, c_addr);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    e = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy) e++;
    end
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d want=0", e);
    end
    load_b_ramp();
    for (int n = 0; n < 100; n++) exp_c[n] = 16'd0;
    launch();
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL mid_a_cleared errors got=%0d want=0", e);
    end
    for (int d = 0; d < N; d++) load(1'b0, d*N + d, 1);
    for (int n = 0; n < 100; n++) exp_c[n] = 16'(n - 50);
    launch();
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL mid_rerun errors got=%0d want=0", e);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    start   = 1'b1;
    ld_en   = 1'b1;
    ld_sel  = 1'b0;
    ld_addr = 7'd0;
    ld_data = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    ld_en = 1'b0;
    total++;
    if ({busy, W_en} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_issue got=%b want=11", {busy, W_en});
    end
    total++;
    if (a_row[7:0] !== 8'd3) begin
      bad++;
      $display("FAIL b2b_fwd got=%0d want=3", a_row[7:0]);
    end
    for (int n = 0; n < 100; n++)
      exp_c[n] = (n < 10) ? 16'(3 * (n - 50)) : 16'(n - 50);
    collect(0, 0);
    e = seq_errs();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL b2b_seq errors got=%0d want=0", e);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturate();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
